// File: rtl/result_monitor_pkg.sv
// Shared definitions for the result monitor: FSM state encoding and the
// default bus symbols that open and close a check session.
package result_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_END,
        ST_DONE
    } state_t;

    localparam logic [29:0] DEFAULT_TEST_PORT = 30'h40;
    localparam logic [31:0] DEFAULT_BEGIN_SYM = 32'h0000_0932;
    localparam logic [31:0] DEFAULT_END_SYM   = 32'h0000_0D5D;

endpackage

// File: rtl/result_monitor_answer_mem.sv
// Answer table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so they survive a monitor reset.
module answer_mem #(
    parameter int DEPTH  = 33,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        ridx,
    output logic [DATA_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (widx < 8'(DEPTH))) begin
            mem[widx[AW-1:0]] <= wdata;
        end
    end

    // Reads past the table (idx == DEPTH while waiting for END) return zero.
    assign rdata = (ridx < 8'(DEPTH)) ? mem[ridx[AW-1:0]] : '0;

endmodule

// File: rtl/result_monitor.sv
// Bus result monitor: snoops writes to a test port, compares a session of
// result words against a loaded answer table, and reports errors/duration.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter int                ADDR_W      = 30,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT   = ADDR_W'(DEFAULT_TEST_PORT),
    parameter logic [DATA_W-1:0] BEGIN_SYM   = DATA_W'(DEFAULT_BEGIN_SYM),
    parameter logic [DATA_W-1:0] END_SYM     = DATA_W'(DEFAULT_END_SYM),
    parameter int                CHECK_NUM   = 33,
    parameter int                ERR_W       = 8,
    parameter int                DUR_W       = 16,
    parameter logic [DUR_W-1:0]  TIMEOUT_CYC = DUR_W'(16'hFFFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              ans_we,
    input  logic [7:0]        ans_idx,
    input  logic [DATA_W-1:0] ans_data,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              timeout,
    output logic              checking
);

    localparam logic [8:0] CHECK_N9 = 9'(CHECK_NUM);
    localparam int         SUM_W    = ((ERR_W > 9) ? ERR_W : 9) + 1;

    state_t            state;
    logic [7:0]        idx;
    logic [DATA_W-1:0] ans_rd;

    logic              port_write;
    logic              is_begin;
    logic              is_end;
    logic              mismatch;
    logic              hit_timeout;
    logic [DUR_W:0]    dur_plus;
    logic [DUR_W-1:0]  dur_next;
    logic [8:0]        idx_after;
    logic [8:0]        err_add;
    logic [SUM_W-1:0]  err_sum;
    logic [ERR_W-1:0]  err_next;

    answer_mem #(
        .DEPTH  (CHECK_NUM),
        .DATA_W (DATA_W)
    ) u_answer_mem (
        .clk   (clk),
        .we    (ans_we && (state == ST_IDLE)),
        .widx  (ans_idx),
        .wdata (ans_data),
        .ridx  (idx),
        .rdata (ans_rd)
    );

    // Per-edge increments: one word compare, plus any missing words charged
    // when the session is cut short by END or by the cycle limit.
    always_comb begin
        port_write  = wen && (addr == TEST_PORT);
        is_begin    = (data == BEGIN_SYM);
        is_end      = (data == END_SYM);
        mismatch    = (data != ans_rd);
        dur_plus    = {1'b0, duration} + (DUR_W+1)'(1);
        dur_next    = dur_plus[DUR_W] ? duration : dur_plus[DUR_W-1:0];
        hit_timeout = (dur_plus >= {1'b0, TIMEOUT_CYC});
        idx_after   = {1'b0, idx} + ((port_write && !is_end) ? 9'd1 : 9'd0);
        err_add     = '0;
        case (state)
            ST_CHECK: begin
                if (port_write && is_end) begin
                    err_add = CHECK_N9 - {1'b0, idx};
                end else begin
                    err_add = {8'd0, port_write && mismatch};
                    if (hit_timeout) begin
                        err_add = err_add + (CHECK_N9 - idx_after);
                    end
                end
            end
            ST_WAIT_END: begin
                if (port_write && !is_end) begin
                    err_add = 9'd1;
                end
            end
            default: err_add = '0;
        endcase
        err_sum  = SUM_W'(error_num) + SUM_W'(err_add);
        err_next = (err_sum > SUM_W'({ERR_W{1'b1}})) ? '1 : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            error_num <= '0;
            duration  <= '0;
            finish    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (port_write && is_begin) begin
                        state     <= ST_CHECK;
                        idx       <= '0;
                        error_num <= '0;
                        duration  <= '0;
                    end
                end
                ST_CHECK: begin
                    duration  <= dur_next;
                    error_num <= err_next;
                    if (port_write && is_end) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx_after[7:0];
                        if (hit_timeout) begin
                            state   <= ST_DONE;
                            timeout <= 1'b1;
                        end else if (idx_after == CHECK_N9) begin
                            state <= ST_WAIT_END;
                        end
                    end
                end
                ST_WAIT_END: begin
                    duration  <= dur_next;
                    error_num <= err_next;
                    if (port_write && is_end) begin
                        state <= ST_DONE;
                    end else if (hit_timeout) begin
                        state   <= ST_DONE;
                        timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    finish <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign checking = (state == ST_CHECK) || (state == ST_WAIT_END);

endmodule

// File: tb/tb_result_monitor.sv
// Scoreboard bench for result_monitor: sessions are described as event lists,
// scored by a session-level model, and checked when finish rises.
module tb_result_monitor;
    import result_monitor_pkg::*;

    localparam int          N    = 33;
    localparam int          TMO  = 100;
    localparam logic [29:0] PORT = DEFAULT_TEST_PORT;
    localparam logic [31:0] BSYM = DEFAULT_BEGIN_SYM;
    localparam logic [31:0] ESYM = DEFAULT_END_SYM;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        ans_we;
    logic [7:0]  ans_idx;
    logic [31:0] ans_data;

    logic [7:0]  error_num;
    logic [15:0] duration;
    logic        finish, timeout, checking;
    logic [3:0]  error_num_s;
    logic [15:0] duration_s;
    logic        finish_s, timeout_s, checking_s;

    result_monitor #(.TIMEOUT_CYC(16'd100)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ans_we(ans_we), .ans_idx(ans_idx), .ans_data(ans_data),
        .error_num(error_num), .duration(duration), .finish(finish),
        .timeout(timeout), .checking(checking)
    );

    result_monitor #(.ERR_W(4), .TIMEOUT_CYC(16'd100)) dut_sat (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ans_we(ans_we), .ans_idx(ans_idx), .ans_data(ans_data),
        .error_num(error_num_s), .duration(duration_s), .finish(finish_s),
        .timeout(timeout_s), .checking(checking_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          off;
        logic [29:0] a;
        logic [31:0] d;
        logic        w;
    } ev_t;

    typedef struct {
        int err;
        int dur;
        int tmo;
    } exp_t;

    ev_t         evs[$];
    exp_t        exp_q[$];
    logic [31:0] answers [N];
    int          checks = 0;
    int          errors = 0;
    int          sessions_seen = 0;
    int          sessions_sent = 0;

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Session-level reference: walk the port writes in order, stop at END or the
    // cycle limit, and charge mismatches, extras and missing words.
    function automatic exp_t model();
        exp_t r;
        int   cnt = 0, mis = 0, extra = 0, e;
        bit   ended = 0;
        r.dur = TMO;
        r.tmo = 1;
        foreach (evs[i]) begin
            if (ended || evs[i].off > TMO || !(evs[i].w && evs[i].a == PORT)) continue;
            if (evs[i].d == ESYM) begin
                ended = 1;
                r.dur = evs[i].off;
                r.tmo = 0;
            end else if (cnt < N) begin
                if (evs[i].d != answers[cnt]) mis++;
                cnt++;
            end else begin
                extra++;
            end
        end
        e = mis + extra + (N - cnt);
        r.err = (e > 255) ? 255 : e;
        return r;
    endfunction

    function automatic logic [31:0] randWord();
        logic [31:0] v;
        do v = $urandom(); while (v == ESYM || v == BSYM);
        return v;
    endfunction

    function automatic logic [31:0] corrupt(input logic [31:0] v);
        logic [31:0] c;
        c = v ^ (32'h1 << $urandom_range(31, 0));
        if (c == ESYM || c == BSYM) c = v ^ 32'h8000_0000;
        return c;
    endfunction

    task automatic addEv(input int off, input logic [29:0] a, input logic [31:0] d, input logic w);
        ev_t e;
        e.off = off; e.a = a; e.d = d; e.w = w;
        evs.push_back(e);
    endtask

    task automatic busCycle(input logic [29:0] a, input logic [31:0] d, input logic w);
        addr = a; data = d; wen = w;
        @(posedge clk);
        #1;
        addr = PORT; data = ESYM; wen = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_error_num", error_num, 0);
        checkOutput("rst_duration", duration, 0);
        checkOutput("rst_finish", finish, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_checking", checking, 0);
    endtask

    task automatic waitSession(input int target);
        int n = 0;
        while (sessions_seen < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("session_done", sessions_seen, target);
    endtask

    // Drives BEGIN then one event (or an idle cycle) per offset; an attempt to
    // overwrite answer 0 mid-session must be ignored.
    task automatic applyStimulus(input int pre_idle);
        int   p = 0, last = 0;
        exp_t e;
        e = model();
        exp_q.push_back(e);
        sessions_sent++;
        repeat (pre_idle) busCycle(PORT, ESYM, 1'b0);
        busCycle(PORT, BSYM, 1'b1);
        foreach (evs[i]) if (evs[i].off > last) last = evs[i].off;
        for (int off = 1; off <= last; off++) begin
            if (off == 2) begin
                ans_we = 1'b1; ans_idx = 8'd0; ans_data = ~answers[0];
            end
            if (p < evs.size() && evs[p].off == off) begin
                busCycle(evs[p].a, evs[p].d, evs[p].w);
                p++;
            end else begin
                busCycle(PORT, ESYM, 1'b0);
            end
            ans_we = 1'b0;
        end
        waitSession(sessions_sent);
        doReset();
    endtask

    task automatic buildWords(input int nwords, input int c1, input int c2, input int end_off);
        evs.delete();
        for (int k = 0; k < nwords; k++) begin
            addEv(k + 1, PORT, (k == c1 || k == c2) ? corrupt(answers[k]) :
                  (k < N ? answers[k] : randWord()), 1'b1);
        end
        if (end_off > 0) addEv(end_off, PORT, ESYM, 1'b1);
    endtask

    // Monitor: score each session when finish rises, including the one-cycle
    // lag between leaving CHECK/WAIT_END and finish.
    logic fin_d = 1'b0;
    logic chk_d = 1'b0;
    int   lag   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_d && !checking) lag = 0;
        else lag++;
        if (finish && !fin_d) begin
            checkOutput("exp_queue", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("error_num", error_num, e.err);
                checkOutput("error_num_sat", error_num_s, (e.err > 15) ? 15 : e.err);
                checkOutput("duration", duration, e.dur);
                checkOutput("timeout", timeout, e.tmo);
                checkOutput("timeout_sat", timeout_s, e.tmo);
                checkOutput("finish_sat", finish_s, 1);
                checkOutput("finish_lag", lag, 1);
                checkOutput("checking_done", checking, 0);
            end
            sessions_seen++;
        end
        fin_d = finish;
        chk_d = checking;
    end

    initial begin
        int off, nw, k;
        rst = 1'b1; addr = PORT; data = ESYM; wen = 1'b0;
        ans_we = 1'b0; ans_idx = '0; ans_data = '0;
        @(posedge clk);
        #1;
        doReset();

        for (int i = 0; i < N; i++) answers[i] = randWord();
        for (int i = 0; i < N + 3; i++) begin
            ans_we = 1'b1;
            ans_idx = 8'(i);
            ans_data = (i < N) ? answers[i] : ~answers[i - N];
            @(posedge clk);
            #1;
        end
        ans_we = 1'b0;

        $display("[TB] directed sessions");
        buildWords(N, -1, -1, 34);      applyStimulus(0);
        buildWords(N, 3, 17, 34);       applyStimulus(0);
        buildWords(30, -1, -1, 31);     applyStimulus(0);
        buildWords(N + 2, -1, -1, 36);  applyStimulus(0);
        buildWords(0, -1, -1, 0);       applyStimulus(0);
        buildWords(10, -1, -1, 100);    applyStimulus(0);

        evs.delete();
        k = 0;
        for (int o = 1; o <= 49; o++) begin
            if (o % 3 == 0) begin
                if (o % 2 == 0) addEv(o, PORT + 30'd1, randWord(), 1'b1);
                else addEv(o, PORT, randWord(), 1'b0);
            end else begin
                addEv(o, PORT, answers[k], 1'b1);
                k++;
            end
        end
        addEv(50, PORT, ESYM, 1'b1);
        applyStimulus(10);

        $display("[TB] reset mid-session");
        busCycle(PORT, BSYM, 1'b1);
        for (int i = 0; i < 5; i++) busCycle(PORT, answers[i] ^ 32'h1, 1'b1);
        checkOutput("mid_checking", checking, 1);
        checkOutput("mid_duration", duration, 5);
        checkOutput("mid_error_num", error_num, 5);
        doReset();
        buildWords(N, -1, -1, 34);      applyStimulus(0);

        $display("[TB] random sessions");
        for (int s = 0; s < 14; s++) begin
            evs.delete();
            off = 0;
            nw = $urandom_range(N + 3, 20);
            for (int i = 0; i < nw; i++) begin
                off += 1 + $urandom_range(1, 0);
                if ($urandom_range(4, 0) == 0) begin
                    addEv(off, PORT + 30'($urandom_range(50, 1)), ESYM, 1'b1);
                    off++;
                end
                if (i >= N) addEv(off, PORT, randWord(), 1'b1);
                else if ($urandom_range(3, 0) == 0) addEv(off, PORT, corrupt(answers[i]), 1'b1);
                else addEv(off, PORT, answers[i], 1'b1);
            end
            if ($urandom_range(4, 0) != 0) addEv(off + 1 + $urandom_range(3, 0), PORT, ESYM, 1'b1);
            applyStimulus($urandom_range(3, 0));
        end

        checkOutput("pending_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
